// File: rtl/uart_apb_sequencer.sv
// APB master for a single UART slave: configures baud/character registers, then
// polls STATUS, draining RX bytes into a holding register and serving TX requesters.
module uart_apb_sequencer #(
    parameter int          NUM_REQ    = 2,
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter logic [2:0]  CHAR_CFG   = 3'b001,
    parameter logic [2:0]  BAUD_FRCTN = 3'd0,
    parameter int          TX_GAP     = 2
) (
    input  logic                   PCLK,
    input  logic                   PRESETN,
    output logic [4:0]             M_PADDR,
    output logic                   M_PSEL,
    output logic                   M_PENABLE,
    output logic                   M_PWRITE,
    output logic [7:0]             M_PWDATA,
    input  logic [7:0]             M_PRDATA,
    input  logic                   M_PREADY,
    input  logic [NUM_REQ-1:0]     REQ_VALID,
    input  logic [8*NUM_REQ-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]     REQ_READY,
    output logic                   RX_VALID,
    output logic [7:0]             RX_DATA,
    input  logic                   RX_READY,
    output logic                   CFG_DONE,
    output logic [2:0]             ERR_STICKY,
    input  logic                   ERR_CLR
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    typedef enum logic [2:0] {S_CFG1, S_CFG2, S_CFG3, S_POLL, S_RDRX, S_WRTX, S_GAP} state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

    state_t            r_state, w_state_nxt;
    phase_t            r_phase, w_phase_nxt;
    logic [2:0]        r_gap, w_gap_nxt;
    logic [IDXW-1:0]   r_ptr, r_grant, w_win_idx, w_ptr_nxt;
    logic [7:0]        r_wdata, w_win_data;
    logic              w_win_found;
    logic [NUM_REQ-1:0] w_rot;
    int                w_sum;
    logic              w_done;
    logic              r_rx_valid;
    logic [7:0]        r_rx_data;
    logic              r_cfg_done;
    logic [2:0]        r_err;
    logic              w_unused;

    assign w_unused = ^M_PRDATA[7:5];
    assign w_done   = (r_phase == PH_ACCESS) && M_PREADY;

    // Rotate so bit 0 is the requester at the round-robin pointer.
    assign w_rot     = NUM_REQ'({REQ_VALID, REQ_VALID} >> r_ptr);
    assign w_ptr_nxt = (int'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_data  = '0;
        w_sum       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_win_found = 1'b1;
                w_sum       = int'(r_ptr) + k;
                if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
                w_win_idx   = IDXW'(w_sum);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDXW'(k) == w_win_idx) w_win_data = REQ_DATA[k*8 +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_gap_nxt   = r_gap;
        if (r_state == S_GAP) begin
            if (r_gap == 3'(TX_GAP - 1)) begin
                w_state_nxt = S_POLL;
                w_gap_nxt   = '0;
            end else begin
                w_gap_nxt = r_gap + 3'd1;
            end
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    if (r_state != S_WRTX || w_win_found) w_phase_nxt = PH_SETUP;
                    else                                  w_state_nxt = S_POLL;
                end
                PH_SETUP: w_phase_nxt = PH_ACCESS;
                PH_ACCESS: begin
                    if (M_PREADY) begin
                        w_phase_nxt = PH_IDLE;
                        case (r_state)
                            S_CFG1: w_state_nxt = S_CFG2;
                            S_CFG2: w_state_nxt = S_CFG3;
                            S_CFG3: w_state_nxt = S_POLL;
                            S_POLL: begin
                                if (M_PRDATA[1] && !r_rx_valid)       w_state_nxt = S_RDRX;
                                else if (M_PRDATA[0] && |REQ_VALID)   w_state_nxt = S_WRTX;
                                else                                  w_state_nxt = S_POLL;
                            end
                            S_WRTX: begin
                                w_state_nxt = S_GAP;
                                w_gap_nxt   = '0;
                            end
                            default: w_state_nxt = S_POLL;
                        endcase
                    end
                end
                default: w_phase_nxt = PH_IDLE;
            endcase
        end
    end

    // Handshakes: a requester byte moves when REQ_READY pulses (REQ_VALID must hold until then);
    // the RX byte moves on any clock edge where RX_VALID && RX_READY.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state    <= S_CFG1;
            r_phase    <= PH_IDLE;
            r_gap      <= '0;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_wdata    <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_cfg_done <= 1'b0;
            r_err      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_gap   <= w_gap_nxt;
            if (r_state == S_WRTX && r_phase == PH_IDLE && w_win_found) begin
                r_grant <= w_win_idx;
                r_wdata <= w_win_data;
            end
            if (r_state == S_WRTX && w_done) r_ptr <= w_ptr_nxt;
            if (r_state == S_RDRX && w_done) begin
                r_rx_data  <= M_PRDATA;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && RX_READY) begin
                r_rx_valid <= 1'b0;
            end
            if (r_state == S_CFG3 && w_done) r_cfg_done <= 1'b1;
            if (ERR_CLR)                          r_err <= '0;
            else if (r_state == S_POLL && w_done) r_err <= r_err | M_PRDATA[4:2];
        end
    end

    assign M_PSEL    = (r_phase != PH_IDLE);
    assign M_PENABLE = (r_phase == PH_ACCESS);

    always_comb begin
        M_PADDR  = '0;
        M_PWRITE = 1'b0;
        M_PWDATA = '0;
        if (M_PSEL) begin
            case (r_state)
                S_CFG1: begin M_PADDR = ADDR_CTRL1;  M_PWRITE = 1'b1; M_PWDATA = BAUD_VALUE[7:0]; end
                S_CFG2: begin M_PADDR = ADDR_CTRL2;  M_PWRITE = 1'b1; M_PWDATA = {BAUD_VALUE[12:8], CHAR_CFG}; end
                S_CFG3: begin M_PADDR = ADDR_CTRL3;  M_PWRITE = 1'b1; M_PWDATA = {5'b0, BAUD_FRCTN}; end
                S_POLL: M_PADDR = ADDR_STATUS;
                S_RDRX: M_PADDR = ADDR_RXDATA;
                S_WRTX: begin M_PADDR = ADDR_TXDATA; M_PWRITE = 1'b1; M_PWDATA = r_wdata; end
                default: M_PADDR = '0;
            endcase
        end
    end

    assign REQ_READY  = (r_state == S_WRTX && w_done) ? (NUM_REQ'(1) << r_grant) : '0;
    assign RX_VALID   = r_rx_valid;
    assign RX_DATA    = r_rx_data;
    assign CFG_DONE   = r_cfg_done;
    assign ERR_STICKY = r_err;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: the bench plays the UART APB slave and
// checks configuration, TX round-robin, RX holding, sticky errors, wait states and reset.
module tb_uart_apb_sequencer;
    localparam int          NUM_REQ    = 2;
    localparam logic [12:0] BAUD_VALUE = 13'h145;
    localparam logic [2:0]  CHAR_CFG   = 3'b011;
    localparam logic [2:0]  BAUD_FRCTN = 3'd3;
    localparam int          TX_GAP     = 2;

    logic                 PCLK = 1'b0;
    logic                 PRESETN;
    logic [4:0]           M_PADDR;
    logic                 M_PSEL;
    logic                 M_PENABLE;
    logic                 M_PWRITE;
    logic [7:0]           M_PWDATA;
    logic [7:0]           M_PRDATA;
    logic                 M_PREADY;
    logic [NUM_REQ-1:0]   REQ_VALID;
    logic [8*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]   REQ_READY;
    logic                 RX_VALID;
    logic [7:0]           RX_DATA;
    logic                 RX_READY;
    logic                 CFG_DONE;
    logic [2:0]           ERR_STICKY;
    logic                 ERR_CLR;

    int n_checks = 0;
    int n_errors = 0;

    uart_apb_sequencer #(
        .NUM_REQ(NUM_REQ), .BAUD_VALUE(BAUD_VALUE), .CHAR_CFG(CHAR_CFG),
        .BAUD_FRCTN(BAUD_FRCTN), .TX_GAP(TX_GAP)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .M_PADDR(M_PADDR), .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE),
        .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
        .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
        .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
        .CFG_DONE(CFG_DONE), .ERR_STICKY(ERR_STICKY), .ERR_CLR(ERR_CLR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at posedge+1 with the DUT in SETUP; idle counts the PSEL=0 cycles skipped.
    task automatic wait_setup(input string tag, output int idle);
        idle = 0;
        while (!(M_PSEL && !M_PENABLE) && idle < 50) begin
            @(posedge PCLK); #1;
            idle++;
        end
        check({tag, "_setup_seen"}, {31'b0, M_PSEL && !M_PENABLE}, 1);
    endtask

    task automatic apb_xfer(input string tag, input logic [4:0] addr, input logic wr,
                            input logic [7:0] wdata, input logic [7:0] rdata, input int waits,
                            input logic [1:0] exp_ready, input logic clr_at_end, output int idle);
        wait_setup(tag, idle);
        check({tag, "_addr"}, M_PADDR, addr);
        check({tag, "_write"}, M_PWRITE, wr);
        if (wr) check({tag, "_wdata"}, M_PWDATA, wdata);
        check({tag, "_ready_setup"}, REQ_READY, 0);
        M_PRDATA = rdata;
        M_PREADY = 1'b0;
        @(posedge PCLK); #1;
        check({tag, "_access"}, {30'b0, M_PSEL, M_PENABLE}, 3);
        check({tag, "_addr_stable"}, M_PADDR, addr);
        if (wr) check({tag, "_wdata_stable"}, M_PWDATA, wdata);
        for (int w = 0; w < waits; w++) begin
            check({tag, "_ready_wait"}, REQ_READY, 0);
            @(posedge PCLK); #1;
            check({tag, "_access_held"}, {30'b0, M_PSEL, M_PENABLE}, 3);
        end
        M_PREADY = 1'b1;
        ERR_CLR  = clr_at_end;
        #1;
        check({tag, "_ready_done"}, REQ_READY, exp_ready);
        @(posedge PCLK); #1;
        M_PREADY = 1'b0;
        ERR_CLR  = 1'b0;
        check({tag, "_psel_gap"}, M_PSEL, 0);
    endtask

    task automatic poll(input logic [7:0] status, output int idle);
        apb_xfer("poll", 5'h10, 1'b0, 8'h00, status, 0, 2'b00, 1'b0, idle);
    endtask

    logic [7:0] tx_exp_data [3];
    logic [1:0] tx_exp_rdy  [3];

    initial begin
        int idle;
        tx_exp_data = '{8'hA1, 8'hB2, 8'hA1};
        tx_exp_rdy  = '{2'b01, 2'b10, 2'b01};
        PRESETN = 1'b0; M_PRDATA = '0; M_PREADY = 1'b0; REQ_VALID = '0; REQ_DATA = '0;
        RX_READY = 1'b0; ERR_CLR = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_psel", M_PSEL, 0);
        check("rst_penable", M_PENABLE, 0);
        check("rst_paddr", M_PADDR, 0);
        check("rst_req_ready", REQ_READY, 0);
        check("rst_rx_valid", RX_VALID, 0);
        check("rst_cfg_done", CFG_DONE, 0);
        check("rst_err", ERR_STICKY, 0);
        PRESETN = 1'b1;

        // Configuration: CTRL2 = {0x145 >> 8 = 5'd1, 3'b011} = 0x0B.
        apb_xfer("cfg1", 5'h08, 1'b1, 8'h45, 8'h00, 0, 2'b00, 1'b0, idle);
        check("cfg1_gap", {31'b0, idle >= 1}, 1);
        check("cfg_done_early1", CFG_DONE, 0);
        apb_xfer("cfg2", 5'h0C, 1'b1, 8'h0B, 8'h00, 0, 2'b00, 1'b0, idle);
        check("cfg2_gap", {31'b0, idle >= 1}, 1);
        check("cfg_done_early2", CFG_DONE, 0);
        apb_xfer("cfg3", 5'h14, 1'b1, 8'h03, 8'h00, 0, 2'b00, 1'b0, idle);
        check("cfg3_gap", {31'b0, idle >= 1}, 1);
        check("cfg_done", CFG_DONE, 1);

        // Round-robin TX with both requesters holding valid.
        REQ_DATA  = 16'hB2A1;
        REQ_VALID = 2'b11;
        for (int i = 0; i < 3; i++) begin
            poll(8'h01, idle);
            if (i > 0) check("tx_gap", {31'b0, idle >= TX_GAP}, 1);
            apb_xfer("tx_rr", 5'h00, 1'b1, tx_exp_data[i], 8'h00, 0, tx_exp_rdy[i], 1'b0, idle);
        end

        // RX has priority; a full holding register blocks further RXDATA reads.
        REQ_VALID = 2'b01;
        poll(8'h03, idle);
        check("tx_gap_last", {31'b0, idle >= TX_GAP}, 1);
        apb_xfer("rx_read", 5'h04, 1'b0, 8'h00, 8'h5A, 0, 2'b00, 1'b0, idle);
        check("rx_valid", RX_VALID, 1);
        check("rx_data", RX_DATA, 8'h5A);
        poll(8'h03, idle);
        apb_xfer("tx_while_full", 5'h00, 1'b1, 8'hA1, 8'h00, 0, 2'b01, 1'b0, idle);
        check("rx_valid_held", RX_VALID, 1);
        check("rx_data_held", RX_DATA, 8'h5A);
        poll(8'h02, idle);
        check("rx_full_gap", {31'b0, idle >= TX_GAP}, 1);
        poll(8'h01, idle);
        REQ_VALID = 2'b00;
        RX_READY = 1'b1;
        @(posedge PCLK); #1;
        RX_READY = 1'b0;
        check("rx_consumed", RX_VALID, 0);

        // Sticky errors and clear priority.
        poll(8'h14, idle);
        check("err_set", ERR_STICKY, 3'b101);
        ERR_CLR = 1'b1;
        @(posedge PCLK); #1;
        ERR_CLR = 1'b0;
        check("err_clr", ERR_STICKY, 3'b000);
        apb_xfer("poll_clr", 5'h10, 1'b0, 8'h00, 8'h14, 0, 2'b00, 1'b1, idle);
        check("err_clr_wins", ERR_STICKY, 3'b000);
        poll(8'h14, idle);
        check("err_reset_again", ERR_STICKY, 3'b101);
        poll(8'h08, idle);
        check("err_accumulate", ERR_STICKY, 3'b111);

        // Wait states on a TX write; pointer is at requester 1.
        REQ_VALID = 2'b11;
        poll(8'h01, idle);
        apb_xfer("tx_wait", 5'h00, 1'b1, 8'hB2, 8'h00, 3, 2'b10, 1'b0, idle);

        // Asynchronous reset during the ACCESS phase of a TX write.
        poll(8'h01, idle);
        wait_setup("tx_rst", idle);
        check("tx_rst_addr", M_PADDR, 5'h00);
        check("tx_rst_wdata", M_PWDATA, 8'hA1);
        @(posedge PCLK); #1;
        check("tx_rst_access", M_PENABLE, 1);
        M_PREADY = 1'b1;
        PRESETN  = 1'b0;
        #1;
        check("mid_rst_psel", M_PSEL, 0);
        check("mid_rst_penable", M_PENABLE, 0);
        check("mid_rst_req_ready", REQ_READY, 0);
        check("mid_rst_cfg_done", CFG_DONE, 0);
        check("mid_rst_err", ERR_STICKY, 0);
        M_PREADY = 1'b0;
        @(posedge PCLK); #1;
        PRESETN = 1'b1;
        apb_xfer("recfg1", 5'h08, 1'b1, 8'h45, 8'h00, 0, 2'b00, 1'b0, idle);
        check("recfg_cfg_done", CFG_DONE, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
